if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of a simple in-order pipeline. Holds the fetch PC
// (pc_f), presents it to a combinational instruction memory, and captures the
// returned word into the IF/ID pipeline register. A two-state FSM (RUN/FAULT)
// traps misaligned or out-of-range fetch addresses; only rst leaves FAULT.
//
// Parameters
//   RESET_PC       PC loaded on reset
//   IMEM_DEPTH     instruction memory depth in 32-bit words
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   stall          hold pc_f and IF/ID
//   flush          turn IF/ID into a bubble on this edge
//   redirect_valid taken branch/jump request (overrides stall)
//   redirect_pc    branch/jump target byte address
//   imem_addr      fetch byte address (== pc_f)
//   imem_instr     instruction word returned for imem_addr
//   instr_d        IF/ID instruction
//   pc_d           IF/ID PC of instr_d
//   pcplus4_d      IF/ID pc_d + 4
//   valid_d        IF/ID holds a real instruction
//   fault          sticky fetch fault, high exactly in FAULT
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pcplus4_d,
   output logic        valid_d,
   output logic        fault
);

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } state_e;

   // One past the last valid byte address; 33 bits so large depths still fit.
   localparam logic [32:0] IMEM_LIMIT = 33'(4 * IMEM_DEPTH);

   state_e      state_q, state_d;
   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pcplus4_q, ifid_pcplus4_d;
   logic        ifid_valid_q, ifid_valid_d;

   logic [31:0] pc_f_plus4;
   logic        pc_f_bad;

   assign pc_f_plus4 = pc_f_q + 32'd4;
   // A misaligned pc_f can only come from a misaligned RESET_PC; trap it too.
   assign pc_f_bad   = ({1'b0, pc_f_q} >= IMEM_LIMIT) || (pc_f_q[1:0] != 2'b00);

   // -------------------------------------------------------------------------
   // Next-state / IF/ID logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would otherwise infer a latch.
      state_d        = state_q;
      pc_f_d         = pc_f_q;
      ifid_instr_d   = ifid_instr_q;
      ifid_pc_d      = ifid_pc_q;
      ifid_pcplus4_d = ifid_pcplus4_q;
      ifid_valid_d   = ifid_valid_q;

      unique case (state_q)
         RUN: begin
            if (redirect_valid) begin
               // Any redirect kills the word fetched from the old path.
               ifid_instr_d   = '0;
               ifid_pc_d      = '0;
               ifid_pcplus4_d = '0;
               ifid_valid_d   = 1'b0;
               if (redirect_pc[1:0] != 2'b00) begin
                  state_d = FAULT;
               end else begin
                  pc_f_d = redirect_pc;
               end
            end else if (pc_f_bad) begin
               // Never latch whatever the memory returns for a bad address.
               state_d        = FAULT;
               ifid_instr_d   = '0;
               ifid_pc_d      = '0;
               ifid_pcplus4_d = '0;
               ifid_valid_d   = 1'b0;
            end else if (stall) begin
               if (flush) begin
                  ifid_instr_d   = '0;
                  ifid_pc_d      = '0;
                  ifid_pcplus4_d = '0;
                  ifid_valid_d   = 1'b0;
               end
            end else begin
               pc_f_d = pc_f_plus4;
               if (flush) begin
                  ifid_instr_d   = '0;
                  ifid_pc_d      = '0;
                  ifid_pcplus4_d = '0;
                  ifid_valid_d   = 1'b0;
               end else begin
                  ifid_instr_d   = imem_instr;
                  ifid_pc_d      = pc_f_q;
                  ifid_pcplus4_d = pc_f_plus4;
                  ifid_valid_d   = 1'b1;
               end
            end
         end

         FAULT: begin
            // Entry into FAULT already wrote a bubble; keep it pinned there.
            ifid_instr_d   = '0;
            ifid_pc_d      = '0;
            ifid_pcplus4_d = '0;
            ifid_valid_d   = 1'b0;
         end

         default: state_d = FAULT;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      if (rst) begin
         state_q        <= RUN;
         pc_f_q         <= RESET_PC;
         ifid_instr_q   <= '0;
         ifid_pc_q      <= '0;
         ifid_pcplus4_q <= '0;
         ifid_valid_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_f_q         <= pc_f_d;
         ifid_instr_q   <= ifid_instr_d;
         ifid_pc_q      <= ifid_pc_d;
         ifid_pcplus4_q <= ifid_pcplus4_d;
         ifid_valid_q   <= ifid_valid_d;
      end
   end

   assign imem_addr = pc_f_q;
   assign instr_d   = ifid_instr_q;
   assign pc_d      = ifid_pc_q;
   assign pcplus4_d = ifid_pcplus4_q;
   assign valid_d   = ifid_valid_q;
   assign fault     = (state_q == FAULT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed bench for if_fetch_stage. The stimulus process drives one edge at
// a time and, right after that edge, queues the hand-computed state expected
// on the outputs. A separate monitor pops one expectation per falling edge
// and compares every output against it.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

   localparam int IMEM_DEPTH = 16;

   typedef struct {
      logic [31:0] pc_f;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcplus4;
      logic        valid;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pcplus4_d;
   logic        valid_d;
   logic        fault;

   logic [31:0] mem [IMEM_DEPTH];
   exp_t        exp_q [$];
   int          assertions = 0;
   int          failures   = 0;
   logic        stim_done  = 1'b0;

   if_fetch_stage #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_DEPTH (IMEM_DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .instr_d        (instr_d),
      .pc_d           (pc_d),
      .pcplus4_d      (pcplus4_d),
      .valid_d        (valid_d),
      .fault          (fault)
   );

   always #5 clk = ~clk;

   // Combinational instruction memory; out-of-range reads return a poison word.
   always_comb begin
      imem_instr = 32'hDEAD_BEEF;
      if (imem_addr < 32'(4 * IMEM_DEPTH)) imem_instr = mem[imem_addr[5:2]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one queued expectation per edge, checked mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("imem_addr", imem_addr,        e.pc_f);
         check("instr_d",   instr_d,          e.instr);
         check("pc_d",      pc_d,             e.pc);
         check("pcplus4_d", pcplus4_d,        e.pcplus4);
         check("valid_d",   {31'd0, valid_d}, {31'd0, e.valid});
         check("fault",     {31'd0, fault},   {31'd0, e.fault});
      end
   end

   // Drive one edge's inputs and queue the state expected after that edge.
   // A bubble is expected with pcplus4 = 0; a valid entry with pc + 4.
   task automatic step(input logic r, input logic st, input logic fl,
                       input logic rv, input logic [31:0] rpc,
                       input logic [31:0] e_pcf, input logic [31:0] e_instr,
                       input logic [31:0] e_pc, input logic e_valid,
                       input logic e_fault);
      exp_t e;
      rst            = r;
      stall          = st;
      flush          = fl;
      redirect_valid = rv;
      redirect_pc    = rpc;
      e.pc_f    = e_pcf;
      e.instr   = e_instr;
      e.pc      = e_pc;
      e.pcplus4 = e_valid ? e_pc + 32'd4 : 32'd0;
      e.valid   = e_valid;
      e.fault   = e_fault;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   initial begin
      mem[0] = 32'h0000_0000;
      mem[1] = 32'h0050_0293;
      mem[2] = 32'h0030_0313;
      mem[3] = 32'h0062_83B3;
      mem[4] = 32'h0000_2403;
      mem[5] = 32'h0010_0493;
      mem[6] = 32'h0094_0533;
      for (int i = 7; i < IMEM_DEPTH; i++) mem[i] = 32'hAA00_0000 + 32'(i);

      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      #1;

      //    rst st fl rv rpc           pc_f      instr         pc_d      v  f
      // Reset held for two edges, with noise on other inputs.
      step(1, 0, 0, 0, 32'h0,        32'h00, 32'h0,        32'h00, 0, 0);
      step(1, 1, 1, 1, 32'h20,       32'h00, 32'h0,        32'h00, 0, 0);
      // Free run: words 0..6.
      step(0, 0, 0, 0, 32'h0,        32'h04, 32'h0000_0000, 32'h00, 1, 0);
      step(0, 0, 0, 0, 32'h0,        32'h08, 32'h0050_0293, 32'h04, 1, 0);
      step(0, 0, 0, 0, 32'h0,        32'h0C, 32'h0030_0313, 32'h08, 1, 0);
      step(0, 0, 0, 0, 32'h0,        32'h10, 32'h0062_83B3, 32'h0C, 1, 0);
      step(0, 0, 0, 0, 32'h0,        32'h14, 32'h0000_2403, 32'h10, 1, 0);
      step(0, 0, 0, 0, 32'h0,        32'h18, 32'h0010_0493, 32'h14, 1, 0);
      step(0, 0, 0, 0, 32'h0,        32'h1C, 32'h0094_0533, 32'h18, 1, 0);

      // Stall for three edges at pc_f = 8.
      step(1, 0, 0, 0, 32'h0,        32'h00, 32'h0,        32'h00, 0, 0);
      step(0, 0, 0, 0, 32'h0,        32'h04, 32'h0000_0000, 32'h00, 1, 0);
      step(0, 0, 0, 0, 32'h0,        32'h08, 32'h0050_0293, 32'h04, 1, 0);
      step(0, 1, 0, 0, 32'h0,        32'h08, 32'h0050_0293, 32'h04, 1, 0);
      step(0, 1, 0, 0, 32'h0,        32'h08, 32'h0050_0293, 32'h04, 1, 0);
      step(0, 1, 0, 0, 32'h0,        32'h08, 32'h0050_0293, 32'h04, 1, 0);
      step(0, 0, 0, 0, 32'h0,        32'h0C, 32'h0030_0313, 32'h08, 1, 0);

      // Redirect to 0x14 under stall at pc_f = 0x0C: one bubble, then target.
      step(0, 1, 0, 1, 32'h14,       32'h14, 32'h0,        32'h00, 0, 0);
      step(0, 0, 0, 0, 32'h0,        32'h18, 32'h0010_0493, 32'h14, 1, 0);
      step(0, 0, 0, 0, 32'h0,        32'h1C, 32'h0094_0533, 32'h18, 1, 0);

      // Flush alone at pc_f = 0x10, then flush together with stall.
      step(0, 0, 0, 1, 32'h10,       32'h10, 32'h0,        32'h00, 0, 0);
      step(0, 0, 1, 0, 32'h0,        32'h14, 32'h0,        32'h00, 0, 0);
      step(0, 0, 0, 0, 32'h0,        32'h18, 32'h0010_0493, 32'h14, 1, 0);
      step(0, 1, 1, 0, 32'h0,        32'h18, 32'h0,        32'h00, 0, 0);
      step(0, 0, 0, 0, 32'h0,        32'h1C, 32'h0094_0533, 32'h18, 1, 0);

      // Run off the end of memory: words 7..15, then fault at pc_f = 0x40.
      for (int k = 0; k < 9; k++)
         step(0, 0, 0, 0, 32'h0, 32'h20 + 32'(4 * k), 32'hAA00_0007 + 32'(k),
              32'h1C + 32'(4 * k), 1, 0);
      step(0, 0, 0, 0, 32'h0,        32'h40, 32'h0,        32'h00, 0, 1);
      // FAULT ignores redirect, stall and flush.
      step(0, 0, 0, 1, 32'h0,        32'h40, 32'h0,        32'h00, 0, 1);
      step(0, 1, 1, 0, 32'h0,        32'h40, 32'h0,        32'h00, 0, 1);
      // Reset recovers.
      step(1, 0, 0, 0, 32'h0,        32'h00, 32'h0,        32'h00, 0, 0);
      step(0, 0, 0, 0, 32'h0,        32'h04, 32'h0000_0000, 32'h00, 1, 0);
      step(0, 0, 0, 0, 32'h0,        32'h08, 32'h0050_0293, 32'h04, 1, 0);

      // Misaligned redirect target faults immediately, pc_f unchanged.
      step(0, 0, 0, 1, 32'h06,       32'h08, 32'h0,        32'h00, 0, 1);
      step(0, 0, 0, 0, 32'h0,        32'h08, 32'h0,        32'h00, 0, 1);
      // Reset overrides FAULT even with other requests present.
      step(1, 1, 0, 1, 32'h20,       32'h00, 32'h0,        32'h00, 0, 0);
      step(0, 0, 0, 0, 32'h0,        32'h04, 32'h0000_0000, 32'h00, 1, 0);

      stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; rst = 1'b0;
      stim_done = 1'b1;
   end

   // Wait (bounded) for the monitor to drain the queue, then summarise.
   initial begin
      int guard;
      guard = 0;
      while (!stim_done && guard < 2000) begin
         @(posedge clk);
         guard++;
      end
      if (!stim_done) begin
         assertions++;
         failures++;
         $display("FAIL stimulus_timeout: stimulus still running after %0d cycles", guard);
      end
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         assertions++;
         failures++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
